// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (LSB first) feeding a first-word-fall-through
// byte FIFO with a valid/ready handshake on the consumer side.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1 and enables
// the parity_error pulse; without it parity_error is held at 0.
module uart_rx_fifo #(
   parameter int BAUD_RATE       = 115200,
   parameter int CLOCK_FREQ      = 48000000,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       frame_error,
   output logic       overrun,
   output logic       parity_error
);

   localparam int BIT_TICKS = CLOCK_FREQ / BAUD_RATE;
   localparam int CW        = $clog2(BIT_TICKS + 1);
   localparam int AW        = FIFO_DEPTH_LOG2;
   localparam int NW        = FIFO_DEPTH_LOG2 + 1;
   localparam int DEPTH     = 1 << FIFO_DEPTH_LOG2;
   localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_TICKS / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   logic          rx_meta_q, rx_s_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          frame_error_q, frame_error_d;
   logic          overrun_q, overrun_d;
   logic          byte_done, expire;
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [NW-1:0] count_q, count_d;
   logic          push, pop;
`ifdef UART_RX_PARITY_EN
   logic          par_bad_q, par_bad_d;
   logic          parity_error_q, parity_error_d;
`endif

   // Two-flop synchroniser; resets to the idle-high line level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Receive FSM next state: bit timing, mid-bit sampling and framing checks.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      byte_done     = 1'b0;
      frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d      = par_bad_q;
      parity_error_d = 1'b0;
`endif
      expire = (cnt_q == '0);
      if (state_q != S_IDLE && !expire) cnt_d = cnt_q - 1'b1;
      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               cnt_d   = HALF_LOAD;
               state_d = S_START;
            end
         end
         S_START: begin
            if (expire) begin
               if (!rx_s_q) begin
                  cnt_d     = FULL_LOAD;
                  bit_idx_d = 3'd0;
                  state_d   = S_DATA;
               end else begin
                  state_d = S_IDLE;   // glitch shorter than half a bit
               end
            end
         end
         S_DATA: begin
            if (expire) begin
               shift_d   = {rx_s_q, shift_q[7:1]};
               cnt_d     = FULL_LOAD;
               bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
               if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (expire) begin
               par_bad_d = rx_s_q ^ (^shift_q);   // even parity over data
               cnt_d     = FULL_LOAD;
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (expire) begin
               if (rx_s_q) begin
                  byte_done = 1'b1;
`ifdef UART_RX_PARITY_EN
                  parity_error_d = par_bad_q;
`endif
                  state_d = S_IDLE;
               end else begin
                  frame_error_d = 1'b1;
                  state_d       = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // Line held low after a bad stop bit: one flag, then wait for idle.
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Receive FSM state and registered error pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         bit_idx_q     <= 3'd0;
         shift_q       <= 8'h00;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q      <= 1'b0;
         parity_error_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         frame_error_q <= frame_error_d;
         overrun_q     <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q      <= par_bad_d;
         parity_error_q <= parity_error_d;
`endif
      end
   end

   // FIFO control: a full FIFO still accepts a byte if the head leaves this cycle.
   always_comb begin
      pop       = rx_valid && rx_ready;
      push      = byte_done && ((count_q < NW'(DEPTH)) || pop);
      overrun_d = byte_done && !push;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage; only occupied slots are ever observed, so no reset needed.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= shift_q;
   end

   assign rx_valid    = (count_q != '0);
   assign rx_data     = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign frame_error = frame_error_q;
   assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_error = parity_error_q;
`else
   assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed frames checked against a queue-based
// model of the receive FIFO and counts of expected error pulses.
module tb_uart_rx_fifo;
   localparam int BAUD = 115200;
   localparam int BT   = 64;            // clocks per bit in this bench
   localparam int CLKF = BAUD * BT;
   localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic       rx_valid, frame_error, overrun, parity_error;
   logic [7:0] rx_data;

   uart_rx_fifo #(.BAUD_RATE(BAUD), .CLOCK_FREQ(CLKF), .FIFO_DEPTH_LOG2(4)) dut (
      .clock(clock), .reset(reset), .rx(rx), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .rx_data(rx_data), .frame_error(frame_error),
      .overrun(overrun), .parity_error(parity_error)
   );

   always #5 clock = ~clock;

   int n_chk = 0, n_err = 0;
   int fe_cnt = 0, ovr_cnt = 0, pe_cnt = 0, vld_cyc = 0;
   int exp_fe = 0, exp_ovr = 0, exp_pe = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Consumer side: every accepted head byte must match the model's oldest byte.
   always @(negedge clock) begin
      if (!reset) begin
         if (frame_error)  fe_cnt++;
         if (overrun)      ovr_cnt++;
         if (parity_error) pe_cnt++;
         if (rx_valid)     vld_cyc++;
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) chk("unexpected_pop", int'(rx_valid), 0);
            else chk("rx_data", int'(rx_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic hold(input logic b, input int n);
      rx = b;
      repeat (n) @(posedge clock);
      #1;
   endtask

   // One serial frame; the model takes the byte at the start of the stop bit,
   // before the receiver's mid-bit sample can make it visible.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit pflip);
      hold(1'b0, BT);
      for (int i = 0; i < 8; i++) hold(b[i], BT);
      if (PAR_EN) hold((^b) ^ pflip, BT);
      if (stop_ok) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(b);
         else exp_ovr++;
         if (PAR_EN && pflip) exp_pe++;
      end else begin
         exp_fe++;
      end
      hold(stop_ok, BT);
      if (stop_ok) hold(1'b1, 4);
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, "_frame_err"}, fe_cnt, exp_fe);
      chk({tag, "_overrun"}, ovr_cnt, exp_ovr);
      chk({tag, "_parity_err"}, pe_cnt, exp_pe);
   endtask

   initial begin
      logic [7:0] b;
      repeat (5) @(posedge clock);
      #1;
      chk("rst_rx_valid", int'(rx_valid), 0);
      chk("rst_rx_data", int'(rx_data), 0);
      chk("rst_frame_err", int'(frame_error), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_parity_err", int'(parity_error), 0);
      reset = 1'b0;
      hold(1'b1, 10);

      // Single byte with the consumer always ready: head visible one cycle.
      rx_ready = 1'b1;
      vld_cyc  = 0;
      send_frame(8'hA5, 1'b1, 1'b0);
      hold(1'b1, 20);
      chk("a5_valid_cycles", vld_cyc, 1);
      chk("a5_drained", exp_q.size(), 0);
      chk_flags("a5");

      // Fill past capacity with no consumer, then drain in order.
      rx_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1, 1'b0);
      hold(1'b1, 10);
      chk("full_rx_valid", int'(rx_valid), 1);
      chk("full_head", int'(rx_data), 0);
      chk_flags("full");
      rx_ready = 1'b1;
      hold(1'b1, 40);
      chk("drain_rx_valid", int'(rx_valid), 0);
      chk("drain_model_empty", exp_q.size(), 0);

      // Short low glitch is rejected as a false start.
      hold(1'b0, 20);
      hold(1'b1, 200);
      chk("glitch_rx_valid", int'(rx_valid), 0);
      chk_flags("glitch");

      // Bad stop bit followed by a long break: one frame error, then recovery.
      send_frame(8'h55, 1'b0, 1'b0);
      hold(1'b0, 2000);
      hold(1'b1, 50);
      chk("break_rx_valid", int'(rx_valid), 0);
      chk_flags("break");
      send_frame(8'h3C, 1'b1, 1'b0);
      hold(1'b1, 40);
      chk("after_break_drained", exp_q.size(), 0);

      // Random bytes, random back-pressure per frame, random idle gaps.
      for (int k = 0; k < 12; k++) begin
         rx_ready = 1'($urandom_range(0, 1));
         b = 8'($urandom);
         send_frame(b, 1'b1, 1'b0);
         hold(1'b1, $urandom_range(0, 40));
      end
      rx_ready = 1'b1;
      hold(1'b1, 40);
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_rx_valid", int'(rx_valid), 0);
      chk_flags("rand");

      // Asynchronous reset mid-frame with bytes queued.
      rx_ready = 1'b0;
      for (int k = 0; k < 3; k++) send_frame(8'($urandom), 1'b1, 1'b0);
      chk("pre_rst_rx_valid", int'(rx_valid), 1);
      b = 8'hC6;
      hold(1'b0, BT);
      for (int i = 0; i < 4; i++) hold(b[i], BT);
      hold(b[4], BT / 2);
      #2 reset = 1'b1;
      #1 chk("rst_async_rx_valid", int'(rx_valid), 0);
      exp_q.delete();
      hold(1'b1, 3);
      reset = 1'b0;
      hold(1'b1, 100);
      send_frame(8'h81, 1'b1, 1'b0);
      hold(1'b1, 20);
      chk("post_rst_rx_valid", int'(rx_valid), 1);
      chk("post_rst_head", int'(rx_data), 'h81);
      rx_ready = 1'b1;
      hold(1'b1, 20);
      chk("post_rst_single", int'(rx_valid), 0);
      chk("post_rst_drained", exp_q.size(), 0);

      // Parity: wrong parity still delivers the byte; correct parity is silent.
      send_frame(8'h07, 1'b1, 1'b1);
      hold(1'b1, 20);
      chk_flags("par_bad");
      send_frame(8'h07, 1'b1, 1'b0);
      hold(1'b1, 20);
      chk_flags("par_ok");
      chk("par_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
